alu_divider: RTL and testbench
==============================

Name: alu_divider

Overview:
- Multi-cycle iterative integer divider.
- Handles the inverse of the ALU multiply path (DIV/REM class ops).
- Sits beside the single-cycle ALU in the execute stage and takes the same two operands.
- Produces quotient and remainder over a fixed number of cycles, using a start/busy/done handshake that the control path stalls on.

Parameters:
- WIDTH, 32, operand/result width in bits. Iteration count equals WIDTH.
- CNT_W, 6, width of the iteration counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  request a division; sampled only in IDLE.
- signed_i  input  1  1 = signed two's-complement division; 0 = unsigned. Sampled with start_i.
- data1_i  input  WIDTH  dividend; sampled with start_i.
- data2_i  input  WIDTH  divisor; sampled with start_i.
- busy_o  output  1  high while an operation is in flight (RUN state).
- done_o  output  1  one-cycle pulse; results are valid this cycle and held afterwards.
- div_zero_o  output  1  divisor was zero for the last operation; held with the results.
- quotient_o  output  WIDTH  quotient of the last completed operation.
- remainder_o  output  WIDTH  remainder of the last completed operation.

Behaviour:
- Reset: when rst_i is high at an edge:
  - state goes to IDLE and the counter is cleared;
  - busy_o=0, done_o=0, div_zero_o=0, quotient_o=0, remainder_o=0.
  - Reset aborts any in-flight operation; no done_o pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 at edge N, latch signed_i, operand magnitudes and result-sign flags.
  - If data2_i != 0: go to RUN, counter=0.
  - If data2_i == 0: go to DONE directly.
  - If start_i=0, stay in IDLE. Outputs hold their previous results.
- RUN:
  - Restoring shift-subtract, one quotient bit per edge, MSB first.
  - Partial remainder is WIDTH+1 bits.
  - After WIDTH iterations (edges N+1..N+WIDTH), apply sign correction, register results, go to DONE.
  - busy_o=1 for exactly WIDTH cycles.
- DONE:
  - done_o=1 for exactly one cycle, then return to IDLE.
  - Latency: start sampled at edge N gives done_o high in the cycle after edge N+WIDTH (N+1 for a zero divisor).
- start_i while in RUN or DONE is ignored and not queued.
- A new operation may start in the cycle immediately after done_o (back-to-back).
- Unsigned mode: plain magnitude division.
- Signed mode:
  - Operate on absolute values.
  - Quotient is negated if the operand signs differ, i.e. truncation toward zero.
  - Remainder takes the sign of the dividend.
- Overflow case (signed, dividend = most-negative value, divisor = -1):
  - quotient_o = most-negative value, remainder_o = 0, div_zero_o = 0.
  - Falls out of the magnitude algorithm; no special casing required.
- Divide by zero (either mode):
  - quotient_o = all ones, remainder_o = dividend unchanged, div_zero_o=1.
- quotient_o, remainder_o and div_zero_o change only at the edge that enters DONE, or at reset.
- Operand inputs may change freely after capture without affecting the in-flight result.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, start_i=0 → all outputs 0, busy_o=0 indefinitely.
- Unsigned: data1_i=100, data2_i=7, signed_i=0, 1-cycle start → busy_o high 32 cycles; done_o pulses once; quotient_o=14, remainder_o=2, div_zero_o=0.
- Signed signs: -7/2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
  - 7/-2 → quotient -3, remainder 1.
  - 0x80000000/0xFFFFFFFF signed → quotient 0x80000000, remainder 0.
- Divide by zero: data1_i=0x12345678, data2_i=0 → done_o in the cycle after capture edge +1; quotient_o=0xFFFFFFFF, remainder_o=0x12345678, div_zero_o=1; busy_o never high.
- Handshake:
  - start_i held high throughout: back-to-back ops with a 34-cycle period; extra starts during RUN/DONE ignored.
  - Operands changed mid-RUN: result still matches the captured values.
- Reset mid-operation: assert rst_i at iteration 10 → next cycle IDLE, all outputs 0, no done_o.
  - A subsequent 0xFFFFFFFF/0x10 unsigned → quotient 0x0FFFFFFF, remainder 0xF.

Source files
------------

// File: rtl/alu_divider_if.sv
// ============================================================================
// Module   : alu_divider_if
// Purpose  : start/busy/done handshake and operand/result bus for alu_divider
// Revision : 1.0
// ============================================================================
`default_nettype none

interface alu_divider_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             busy_o;
  logic             done_o;
  logic             div_zero_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;

  modport master (
    output start_i, signed_i, data1_i, data2_i,
    input  busy_o, done_o, div_zero_o, quotient_o, remainder_o
  );

  modport slave (
    input  start_i, signed_i, data1_i, data2_i,
    output busy_o, done_o, div_zero_o, quotient_o, remainder_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_divider.sv
// ============================================================================
// Module   : alu_divider
// Purpose  : multi-cycle restoring integer divider (DIV/REM, signed/unsigned)
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] w_mag1, w_mag2;
  logic [WIDTH:0]   w_shifted, w_diff;
  logic [WIDTH-1:0] w_rem_step, w_quo_step;

  // Remainder stays below the divisor, so only the shifted trial value needs the extra bit.
  always_comb begin
    w_mag1     = (bus.signed_i && bus.data1_i[WIDTH-1]) ? -bus.data1_i : bus.data1_i;
    w_mag2     = (bus.signed_i && bus.data2_i[WIDTH-1]) ? -bus.data2_i : bus.data2_i;
    w_shifted  = {rem_q, quo_q[WIDTH-1]};
    w_diff     = w_shifted - {1'b0, dvs_q};
    w_rem_step = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    w_quo_step = {quo_q[WIDTH-2:0], ~w_diff[WIDTH]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          negq_d = bus.signed_i & (bus.data1_i[WIDTH-1] ^ bus.data2_i[WIDTH-1]);
          negr_d = bus.signed_i & bus.data1_i[WIDTH-1];
          quo_d  = w_mag1;
          dvs_d  = w_mag2;
          rem_d  = '0;
          cnt_d  = '0;
          if (bus.data2_i == '0) begin
            quotient_d  = '1;
            remainder_d = bus.data1_i;
            div_zero_d  = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d = w_rem_step;
        quo_d = w_quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          quotient_d  = negq_q ? -w_quo_step : w_quo_step;
          remainder_d = negr_q ? -w_rem_step : w_rem_step;
          div_zero_d  = 1'b0;
          state_d     = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign bus.busy_o      = (state_q == S_RUN);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.div_zero_o  = div_zero_q;
  assign bus.quotient_o  = quotient_q;
  assign bus.remainder_o = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_divider.sv
// ============================================================================
// Module   : tb_alu_divider
// Purpose  : directed self-checking bench for alu_divider
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_divider;

  logic clk_i;
  logic rst_i;
  int   n_checks;
  int   n_errors;

  alu_divider_if #(.WIDTH(32)) dif ();

  alu_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (dif)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done_o, counting busy cycles and edges since capture.
  task automatic wait_done(output int lat, output int busy_cnt, input bit scramble);
    lat      = 0;
    busy_cnt = 0;
    while (!dif.done_o && lat < 100) begin
      if (dif.busy_o) busy_cnt++;
      @(posedge clk_i);
      #1;
      lat++;
      if (scramble && lat == 5) begin
        dif.data1_i = 32'hDEAD_BEEF;
        dif.data2_i = 32'h0000_0003;
      end
    end
    check_eq("done_timeout", {31'd0, dif.done_o}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                        input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r,
                        input logic exp_z, input bit scramble);
    int lat, bc;
    @(negedge clk_i);
    dif.start_i  = 1'b1;
    dif.signed_i = sgn;
    dif.data1_i  = d1;
    dif.data2_i  = d2;
    @(posedge clk_i);
    #1;
    dif.start_i = 1'b0;
    wait_done(lat, bc, scramble);
    check_eq({tag, "_q"}, dif.quotient_o, exp_q);
    check_eq({tag, "_r"}, dif.remainder_o, exp_r);
    check_eq({tag, "_z"}, {31'd0, dif.div_zero_o}, {31'd0, exp_z});
    check_eq({tag, "_lat"}, lat, exp_z ? 32'd0 : 32'd32);
    check_eq({tag, "_busy"}, bc, exp_z ? 32'd0 : 32'd32);
    @(posedge clk_i);
    #1;
    check_eq({tag, "_pulse"}, {31'd0, dif.done_o}, 32'd0);
    check_eq({tag, "_hold"}, dif.quotient_o, exp_q);
  endtask

  initial begin
    int t, t1, bc;
    n_checks     = 0;
    n_errors     = 0;
    rst_i        = 1'b1;
    dif.start_i  = 1'b0;
    dif.signed_i = 1'b0;
    dif.data1_i  = '0;
    dif.data2_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_eq("rst_busy", {31'd0, dif.busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, dif.done_o}, 32'd0);
    check_eq("rst_z", {31'd0, dif.div_zero_o}, 32'd0);
    check_eq("rst_q", dif.quotient_o, 32'd0);
    check_eq("rst_r", dif.remainder_o, 32'd0);
    bc = 0;
    repeat (5) begin
      @(posedge clk_i);
      #1;
      if (dif.busy_o || dif.done_o) bc++;
    end
    check_eq("idle_quiet", bc, 32'd0);

    run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0);
    run_op("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    run_op("sm7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    run_op("um7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
    run_op("dz", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
    run_op("dz_s", 32'h8000_0001, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 1'b0);
    run_op("scram", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);

    // start_i held high: ops should repeat every 34 cycles
    @(negedge clk_i);
    dif.start_i  = 1'b1;
    dif.signed_i = 1'b0;
    dif.data1_i  = 32'd1000;
    dif.data2_i  = 32'd10;
    @(posedge clk_i);
    #1;
    wait_done(t1, bc, 1'b0);
    check_eq("b2b_q0", dif.quotient_o, 32'd100);
    check_eq("b2b_lat0", t1, 32'd32);
    dif.data1_i = 32'd77;
    dif.data2_i = 32'd5;
    @(posedge clk_i);
    #1;
    wait_done(t, bc, 1'b0);
    dif.start_i = 1'b0;
    check_eq("b2b_period", t + 1, 32'd34);
    check_eq("b2b_busy", bc, 32'd32);
    check_eq("b2b_q1", dif.quotient_o, 32'd15);
    check_eq("b2b_r1", dif.remainder_o, 32'd2);
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("b2b_drain", {31'd0, dif.busy_o | dif.done_o}, 32'd0);

    // reset at iteration 10 aborts the op
    @(negedge clk_i);
    dif.start_i = 1'b1;
    dif.data1_i = 32'd500;
    dif.data2_i = 32'd3;
    @(posedge clk_i);
    #1;
    dif.start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_eq("mrst_busy", {31'd0, dif.busy_o}, 32'd0);
    check_eq("mrst_done", {31'd0, dif.done_o}, 32'd0);
    check_eq("mrst_q", dif.quotient_o, 32'd0);
    check_eq("mrst_r", dif.remainder_o, 32'd0);
    check_eq("mrst_z", {31'd0, dif.div_zero_o}, 32'd0);
    bc = 0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (dif.done_o || dif.busy_o) bc++;
    end
    check_eq("mrst_nodone", bc, 32'd0);
    run_op("post_rst", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
